// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000-style bus initiator.
//   bus_state_e : half-state sequencer encoding (IDLE, S0..S7)
//   bus_req_t   : request fields latched at acceptance
package m68k_bus_pkg;

    localparam int unsigned ADDR_W          = 23;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned DEFAULT_TIMEOUT = 64;
    localparam int unsigned DEFAULT_TMR_W   = 7;

    localparam logic RW_READ    = 1'b1;
    localparam logic RW_WRITE   = 1'b0;
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        S0, S1, S2, S3, S4, S5, S6, S7
    } bus_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic              uds;
        logic              lds;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // A request with no byte lane selected cannot produce a bus cycle.
    function automatic logic lanes_empty(input bus_req_t r);
        return !(r.uds || r.lds);
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// DTACK wait-state counter.
//   CLK, RESET_n : clock, async active-low reset
//   clear        : zero the count (wins over enable)
//   enable       : advance the count by one
//   expired_c    : count has reached TIMEOUT_CYCLES-1 (combinational)
module bus_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TMR_W          = 7
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [TMR_W-1:0] count;

    // Wait-cycle count
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TMR_W'(1);
        end
    end

    assign expired_c = (count == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/m68k_bus_initiator.sv
// 68000-style bus master: turns one request into an S0..S7 bus cycle.
//   CLK, RESET_n                      : clock (one half-state), async active-low reset
//   bus_grant                         : bus ownership, sampled in IDLE only
//   req_valid/req_ready/req_*         : request handshake and fields
//   rsp_valid/rsp_rdata/rsp_err       : completion pulse, read data, error
//   ADDR/AS_n/UDS_n/LDS_n/RW          : bus address and strobes
//   D_OUT/D_OE/D_IN/DTACK_n           : data bus and slave acknowledge
// Outputs are registered from the next-state decision, so each output
// level reflects the state the sequencer is in during that CLK.
module m68k_bus_initiator
    import m68k_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned TMR_W          = DEFAULT_TMR_W
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              bus_grant,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_rw,
    input  logic              req_uds,
    input  logic              req_lds,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ADDR,
    output logic              AS_n,
    output logic              UDS_n,
    output logic              LDS_n,
    output logic              RW,
    output logic [DATA_W-1:0] D_OUT,
    output logic              D_OE,
    input  logic [DATA_W-1:0] D_IN,
    input  logic              DTACK_n
);

    bus_state_e        state_q, state_d;
    bus_req_t          req_q, req_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] dout_d, rdata_d;
    logic              as_n_d, uds_n_d, lds_n_d, rw_d, oe_d;
    logic              ready_d, valid_d, err_d;
    logic              tmr_clear, tmr_enable, tmr_expired;

    bus_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_wait_timer (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .clear     (tmr_clear),
        .enable    (tmr_enable),
        .expired_c (tmr_expired)
    );

    // Sequencer next state and next bus/response levels
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = ADDR;
        dout_d     = D_OUT;
        rdata_d    = rsp_rdata;
        as_n_d     = AS_n;
        uds_n_d    = UDS_n;
        lds_n_d    = LDS_n;
        rw_d       = RW;
        oe_d       = D_OE;
        ready_d    = 1'b0;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        tmr_clear  = 1'b1;
        tmr_enable = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && bus_grant) begin
                    req_d   = '{addr: req_addr, rw: req_rw, uds: req_uds,
                                lds: req_lds, wdata: req_wdata};
                    ready_d = 1'b1;
                    rdata_d = '0;
                    state_d = S0;
                    if (req_uds || req_lds) begin
                        rw_d   = req_rw;
                        addr_d = req_addr;
                    end
                end
            end
            S0: begin
                if (lanes_empty(req_q)) begin
                    // Nothing to transfer: report an error without touching the bus.
                    state_d = S7;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = S1;
                end
            end
            S1: begin
                state_d = S2;
                as_n_d  = STROBE_ON;
                if (req_q.rw == RW_READ) begin
                    uds_n_d = !req_q.uds;
                    lds_n_d = !req_q.lds;
                end
            end
            S2: begin
                state_d = S3;
                if (req_q.rw == RW_WRITE) begin
                    dout_d = req_q.wdata;
                    oe_d   = 1'b1;
                end
            end
            S3: begin
                state_d = S4;
                if (req_q.rw == RW_WRITE) begin
                    uds_n_d = !req_q.uds;
                    lds_n_d = !req_q.lds;
                end
            end
            S4: begin
                // DTACK wins over a timeout landing on the same cycle.
                if (!DTACK_n) begin
                    state_d = S5;
                end else if (tmr_expired) begin
                    state_d = S7;
                    as_n_d  = STROBE_OFF;
                    uds_n_d = STROBE_OFF;
                    lds_n_d = STROBE_OFF;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tmr_clear  = 1'b0;
                    tmr_enable = 1'b1;
                end
            end
            S5: state_d = S6;
            S6: begin
                state_d = S7;
                as_n_d  = STROBE_OFF;
                uds_n_d = STROBE_OFF;
                lds_n_d = STROBE_OFF;
                valid_d = 1'b1;
                if (req_q.rw == RW_READ) begin
                    rdata_d = D_IN;
                end
            end
            S7: begin
                state_d = IDLE;
                oe_d    = 1'b0;
                rw_d    = RW_READ;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and registered outputs
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            ADDR      <= '0;
            D_OUT     <= '0;
            rsp_rdata <= '0;
            AS_n      <= STROBE_OFF;
            UDS_n     <= STROBE_OFF;
            LDS_n     <= STROBE_OFF;
            RW        <= RW_READ;
            D_OE      <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ADDR      <= addr_d;
            D_OUT     <= dout_d;
            rsp_rdata <= rdata_d;
            AS_n      <= as_n_d;
            UDS_n     <= uds_n_d;
            LDS_n     <= lds_n_d;
            RW        <= rw_d;
            D_OE      <= oe_d;
            req_ready <= ready_d;
            rsp_valid <= valid_d;
            rsp_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Scoreboard bench for m68k_bus_initiator: randomized requests, a slave
// model answering with programmable DTACK delay, and a response monitor.
module tb_m68k_bus_initiator;
    import m68k_bus_pkg::*;

    localparam int TIMEOUT = 64;
    localparam int NEVER   = 1000;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        bus_grant = 1'b0, req_valid = 1'b0, req_ready;
    logic [22:0] req_addr = '0;
    logic        req_rw = 1'b1, req_uds = 1'b0, req_lds = 1'b0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [22:0] ADDR;
    logic        AS_n, UDS_n, LDS_n, RW, D_OE;
    logic [15:0] D_OUT;
    logic [15:0] D_IN = '0;
    logic        DTACK_n = 1'b1;

    m68k_bus_initiator #(.TIMEOUT_CYCLES(TIMEOUT), .TMR_W(7)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .bus_grant(bus_grant),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rw(req_rw), .req_uds(req_uds), .req_lds(req_lds), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ADDR(ADDR), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
        .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN), .DTACK_n(DTACK_n)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [22:0] addr;
        logic        rw, uds, lds;
        logic [15:0] wdata, rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        int          delay;
        logic [15:0] data;
    } slv_t;

    exp_t exp_q[$];
    slv_t slv_q[$];
    int   n_cmp = 0, n_mis = 0;
    int   cyc = 0, t_ready = 0, n_ready = 0;

    // Bus snapshot taken by the slave in the first wait half-state
    logic        as_seen = 1'b0, snap_valid = 1'b0;
    logic [22:0] snap_addr;
    logic        snap_rw, snap_uds_n, snap_lds_n, snap_oe;
    logic [15:0] snap_dout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: setup takes S0..S3, then DTACK wait, then S5..S7.
    function automatic exp_t model(input logic [22:0] a, input logic rw, input logic u,
                                   input logic l, input logic [15:0] wd,
                                   input logic [15:0] sd, input int delay);
        exp_t e;
        e.addr = a; e.rw = rw; e.uds = u; e.lds = l; e.wdata = wd;
        if (!u && !l) begin
            e.err = 1'b1; e.rdata = '0; e.lat = 1;
        end else if (delay >= TIMEOUT) begin
            e.err = 1'b1; e.rdata = '0; e.lat = 4 + TIMEOUT;
        end else begin
            e.err = 1'b0; e.rdata = rw ? sd : 16'h0; e.lat = 7 + delay;
        end
        return e;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Slave: acknowledges after a per-cycle delay counted from AS_n falling
    int   as_cnt = 0;
    slv_t cur;
    always @(negedge CLK) begin
        if (!RESET_n) begin
            as_cnt = 0; DTACK_n = 1'b1; as_seen = 1'b0; snap_valid = 1'b0;
        end else if (!AS_n) begin
            as_seen = 1'b1;
            if (as_cnt == 0) begin
                chk("slave_entry", 32'(slv_q.size() != 0), 1);
                if (slv_q.size() != 0) cur = slv_q.pop_front();
                else cur = '{NEVER, 16'h0};
                D_IN = cur.data;
            end
            if (as_cnt == 2) begin
                snap_valid = 1'b1; snap_addr = ADDR; snap_rw = RW;
                snap_uds_n = UDS_n; snap_lds_n = LDS_n; snap_oe = D_OE; snap_dout = D_OUT;
            end
            DTACK_n = (as_cnt >= 2 + cur.delay) ? 1'b0 : 1'b1;
            as_cnt++;
        end else begin
            as_cnt = 0; DTACK_n = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every response
    exp_t e;
    always @(negedge CLK) begin
        if (RESET_n) begin
            if (req_ready) begin t_ready = cyc; n_ready++; end
            if (rsp_valid) begin
                chk("rsp_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("latency", 32'(cyc - t_ready), 32'(e.lat));
                    chk("strobes_off", 32'({AS_n, UDS_n, LDS_n}), 32'(3'b111));
                    chk("bus_cycle", 32'(as_seen), 32'(e.uds | e.lds));
                    if (snap_valid) begin
                        chk("addr", 32'(snap_addr), 32'(e.addr));
                        chk("rw", 32'(snap_rw), 32'(e.rw));
                        chk("uds_n", 32'(snap_uds_n), 32'(!e.uds));
                        chk("lds_n", 32'(snap_lds_n), 32'(!e.lds));
                        chk("d_oe", 32'(snap_oe), 32'(!e.rw));
                        if (!e.rw) chk("d_out", 32'(snap_dout), 32'(e.wdata));
                    end
                end
                as_seen = 1'b0; snap_valid = 1'b0;
            end
        end
    end

    task automatic issue(input logic [22:0] a, input logic rw, input logic u, input logic l,
                         input logic [15:0] wd, input logic [15:0] sd, input int delay);
        bit got;
        exp_q.push_back(model(a, rw, u, l, wd, sd, delay));
        if (u || l) slv_q.push_back('{delay, sd});
        @(negedge CLK);
        bus_grant = 1'b1; req_addr = a; req_rw = rw; req_uds = u; req_lds = l;
        req_wdata = wd; req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge CLK); #1; got = req_ready;
        end
        chk("req_accept", 32'(got), 1);
        // Fields must no longer matter; grant may drop mid-cycle.
        req_valid = 1'b0; req_addr = 23'($urandom); req_rw = 1'($urandom);
        req_uds = 1'($urandom); req_lds = 1'($urandom); req_wdata = 16'($urandom);
        bus_grant = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        bit  got;
        int  r0, lanes, dly;
        repeat (3) @(negedge CLK);
        chk("rst_ctrl", 32'({AS_n, UDS_n, LDS_n, RW, D_OE, req_ready, rsp_valid, rsp_err}),
            32'(8'b1111_0000));
        chk("rst_addr", 32'(ADDR), 0);
        chk("rst_dout", 32'(D_OUT), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        RESET_n = 1'b1;
        repeat (2) @(negedge CLK);

        issue(23'h748000, RW_READ, 1, 1, 16'h0, 16'hA55A, 0);
        issue(23'h750800, RW_WRITE, 0, 1, 16'h3456, 16'h0, 0);
        issue(23'h748001, RW_READ, 1, 1, 16'h0, 16'h1234, 5);
        issue(23'h748002, RW_READ, 1, 1, 16'h0, 16'hBEEF, NEVER);
        issue(23'h000100, RW_READ, 0, 0, 16'h0, 16'h5555, 0);
        issue(23'h7FFFFF, RW_READ, 1, 0, 16'h0, 16'hC3C3, TIMEOUT - 1);
        issue(23'h000000, RW_WRITE, 1, 1, 16'hFFFF, 16'h0, TIMEOUT);

        for (int i = 0; i < 40; i++) begin
            lanes = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            dly   = ($urandom_range(0, 19) == 0) ? NEVER : $urandom_range(0, 6);
            issue(23'($urandom), 1'($urandom), lanes[1], lanes[0], 16'($urandom),
                  16'($urandom), dly);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge CLK);
        chk("drain", 32'(exp_q.size()), 0);
        repeat (3) @(negedge CLK);

        // Reset in the middle of a write cycle (S5)
        slv_q.push_back('{0, 16'h0});
        @(negedge CLK);
        bus_grant = 1'b1; req_addr = 23'h750800; req_rw = RW_WRITE; req_uds = 1'b0;
        req_lds = 1'b1; req_wdata = 16'h3456; req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge CLK); #1; got = req_ready;
        end
        chk("req_accept_rst", 32'(got), 1);
        req_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        chk("s5_strobes", 32'({AS_n, UDS_n, LDS_n, D_OE}), 32'(4'b0101));
        #2 RESET_n = 1'b0;
        #1;
        chk("rst_abort", 32'({AS_n, UDS_n, LDS_n, D_OE, rsp_valid, RW}), 32'(6'b111001));
        r0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1; r0 += int'(rsp_valid);
        end
        chk("rst_no_rsp", 32'(r0), 0);
        @(negedge CLK); RESET_n = 1'b1;
        repeat (2) @(negedge CLK);

        // No grant: request must not be accepted
        bus_grant = 1'b0; req_valid = 1'b1; req_uds = 1'b1; req_lds = 1'b1;
        r0 = n_ready;
        repeat (12) @(negedge CLK);
        chk("no_grant_ready", 32'(n_ready - r0), 0);
        chk("no_grant_as", 32'(AS_n), 1);
        req_valid = 1'b0;
        repeat (2) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
